audio_mix_sequencer: RTL and testbench

- Generates the HDMI audio sample tick from the pixel clock.
- Mixes the SuperSprite, Mockingboard L/R and Apple speaker sources into one stereo 16-bit sample pair per tick.
- Uses a single shared accumulator/saturation datapath, sequenced by an FSM.
- Sits between the audio-producing cards and the hdmi block's clk_audio/audio_sample_word inputs, replacing ad-hoc per-channel adders and the free-running speaker pulse logic.

---
 rtl/audio_mix_sequencer_if.sv | 28 ++
 rtl/audio_mix_sequencer.sv | 156 +++++++++++++++
 tb/tb_audio_mix_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_mix_sequencer_if.sv
// Audio source and published-sample bundle between the audio cards, the mixer and the hdmi block.
// master drives the sources and consumes the samples; slave is the mixer itself.
interface audio_mix_sequencer_if;
   logic [15:0] ssp_audio_i;
   logic [9:0]  mb_audio_l_i;
   logic [9:0]  mb_audio_r_i;
   logic        speaker_bit_i;
   logic        speaker_en_i;
   logic        mute_i;
   logic        sat_clear_i;
   logic        audio_tick_o;
   logic [15:0] sample_l_o;
   logic [15:0] sample_r_o;
   logic        sample_valid_o;
   logic        sat_flag_o;

   modport master (
      output ssp_audio_i, mb_audio_l_i, mb_audio_r_i, speaker_bit_i,
             speaker_en_i, mute_i, sat_clear_i,
      input  audio_tick_o, sample_l_o, sample_r_o, sample_valid_o, sat_flag_o
   );

   modport slave (
      input  ssp_audio_i, mb_audio_l_i, mb_audio_r_i, speaker_bit_i,
             speaker_en_i, mute_i, sat_clear_i,
      output audio_tick_o, sample_l_o, sample_r_o, sample_valid_o, sat_flag_o
   );
endinterface

// File: rtl/audio_mix_sequencer.sv
// Audio tick generator and stereo mixer sharing one saturating accumulator; sample published
// 11 cycles after each tick, no backpressure (the hdmi side samples on sample_valid_o).
module audio_mix_sequencer #(
   parameter int          CLOCK_SPEED_HZ    = 27_000_000,
   parameter int          AUDIO_RATE        = 44100,
   parameter logic [15:0] SPEAKER_LEVEL     = 16'h2000,
   parameter int          SPEAKER_PULSE_LEN = 255
) (
   input logic                  clk_pixel,
   input logic                  reset,
   audio_mix_sequencer_if.slave mix
);
   localparam int DIV   = CLOCK_SPEED_HZ / AUDIO_RATE;
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   generate
      if (DIV < 16) begin : g_div_check
         $error("audio_mix_sequencer: CLOCK_SPEED_HZ / AUDIO_RATE must be at least 16");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, LATCH, ACC0, ACC1, ACC2, SAT, PUBLISH} state_t;

   state_t            state_q, state_d;
   logic              ch_q, ch_d;
   logic [DIV_W-1:0]  div_cnt;
   logic              tick;
   logic              spk_meta, spk_s;
   logic              spk_prev;
   logic [7:0]        spk_cnt;
   logic              spk_on;
   logic [15:0]       ssp_q;
   logic [9:0]        mb_l_q, mb_r_q;
   logic [17:0]       acc;
   logic [15:0]       hold_l, hold_r;
   logic              do_latch, do_acc0, do_acc1, do_acc2, do_sat, do_publish;
   logic [9:0]        mb_sel;
   logic              clamp;
   logic [15:0]       sat_val;

   assign tick             = (div_cnt == DIV_W'(DIV - 1));
   assign mix.audio_tick_o = tick;

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         div_cnt  <= '0;
         spk_meta <= 1'b0;
         spk_s    <= 1'b0;
      end else begin
         div_cnt  <= tick ? '0 : div_cnt + DIV_W'(1);
         spk_meta <= mix.speaker_bit_i;
         spk_s    <= spk_meta;
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         state_q <= IDLE;
         ch_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
      end
   end

   // A tick outside IDLE is dropped; the running sequence is never restarted.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      case (state_q)
         IDLE:    if (tick) state_d = LATCH;
         LATCH:   begin state_d = ACC0; ch_d = 1'b0; end
         ACC0:    state_d = ACC1;
         ACC1:    state_d = ACC2;
         ACC2:    state_d = SAT;
         SAT:     if (ch_q) state_d = PUBLISH;
                  else begin state_d = ACC0; ch_d = 1'b1; end
         PUBLISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      do_latch   = 1'b0;
      do_acc0    = 1'b0;
      do_acc1    = 1'b0;
      do_acc2    = 1'b0;
      do_sat     = 1'b0;
      do_publish = 1'b0;
      case (state_q)
         LATCH:   do_latch   = 1'b1;
         ACC0:    do_acc0    = 1'b1;
         ACC1:    do_acc1    = 1'b1;
         ACC2:    do_acc2    = 1'b1;
         SAT:     do_sat     = 1'b1;
         PUBLISH: do_publish = 1'b1;
         default: ;
      endcase
   end

   assign mb_sel  = ch_q ? mb_r_q : mb_l_q;
   assign clamp   = (acc > 18'h0FFFF);
   assign sat_val = clamp ? 16'hFFFF : acc[15:0];

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         ssp_q              <= '0;
         mb_l_q             <= '0;
         mb_r_q             <= '0;
         spk_on             <= 1'b0;
         spk_prev           <= 1'b0;
         spk_cnt            <= '0;
         acc                <= '0;
         hold_l             <= '0;
         hold_r             <= '0;
         mix.sample_l_o     <= '0;
         mix.sample_r_o     <= '0;
         mix.sample_valid_o <= 1'b0;
         mix.sat_flag_o     <= 1'b0;
      end else begin
         if (do_latch) begin
            ssp_q    <= mix.ssp_audio_i;
            mb_l_q   <= mix.mb_audio_l_i;
            mb_r_q   <= mix.mb_audio_r_i;
            // The pulse sounds only while the previous level is high and the window is open.
            spk_on   <= spk_prev && (spk_cnt != 8'd0) && mix.speaker_en_i;
            spk_prev <= spk_s;
            if (spk_s != spk_prev) begin
               spk_cnt <= 8'(SPEAKER_PULSE_LEN);
            end else if (spk_cnt != 8'd0) begin
               spk_cnt <= spk_cnt - 8'd1;
            end
            acc <= '0;
         end
         if (do_acc0) acc <= {2'b00, ssp_q};
         if (do_acc1) acc <= acc + {4'b0000, mb_sel, 4'b0000};
         if (do_acc2) acc <= acc + (spk_on ? {2'b00, SPEAKER_LEVEL} : 18'd0);
         if (do_sat) begin
            if (ch_q) hold_r <= sat_val;
            else      hold_l <= sat_val;
         end

         if (do_sat && clamp) begin
            mix.sat_flag_o <= 1'b1;
         end else if (mix.sat_clear_i) begin
            mix.sat_flag_o <= 1'b0;
         end

         mix.sample_valid_o <= do_publish;
         if (do_publish) begin
            mix.sample_l_o <= mix.mute_i ? 16'h0000 : hold_l;
            mix.sample_r_o <= mix.mute_i ? 16'h0000 : hold_r;
         end
      end
   end
endmodule

// File: tb/tb_audio_mix_sequencer.sv
// Bench for audio_mix_sequencer: fast-divider instance for mixing/speaker/reset behaviour,
// default-parameter instance for the 612-cycle tick period.
module tb_audio_mix_sequencer;
   localparam int DIV     = 32;
   localparam int DIV_DEF = 612;
   localparam int PLEN    = 255;

   logic clk_pixel = 1'b0;
   logic reset     = 1'b1;
   always #5 clk_pixel = ~clk_pixel;

   audio_mix_sequencer_if mix ();
   audio_mix_sequencer_if mix_def ();

   audio_mix_sequencer #(.CLOCK_SPEED_HZ(32_000), .AUDIO_RATE(1000)) dut (
      .clk_pixel(clk_pixel), .reset(reset), .mix(mix));
   audio_mix_sequencer dut_def (
      .clk_pixel(clk_pixel), .reset(reset), .mix(mix_def));

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk_pixel) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out waiting for the DUT, expected an event", name);
   endtask

   // Tick period and tick-to-valid latency, watched continuously on both instances.
   int last_tick = -1;
   always @(negedge clk_pixel) begin
      if (reset) last_tick = -1;
      else begin
         if (mix.audio_tick_o) begin
            if (last_tick >= 0) check("tick_period", cyc - last_tick, DIV);
            last_tick = cyc;
         end
         if (mix.sample_valid_o)
            check("valid_latency", (last_tick >= 0) ? cyc - last_tick : -1, 11);
      end
   end

   int last_tick_def = -1;
   int def_ticks     = 0;
   always @(negedge clk_pixel) begin
      if (reset) last_tick_def = -1;
      else begin
         if (mix_def.audio_tick_o) begin
            if (last_tick_def >= 0) check("def_tick_period", cyc - last_tick_def, DIV_DEF);
            last_tick_def = cyc;
            def_ticks++;
         end
         if (mix_def.sample_valid_o)
            check("def_valid_latency", (last_tick_def >= 0) ? cyc - last_tick_def : -1, 11);
      end
   end

   // Reference model, evaluated once per audio tick.
   logic sat_m      = 1'b0;
   logic spk_prev_m = 1'b0;
   int   spk_cnt_m  = 0;

   function automatic logic [16:0] mix_chan(input logic [15:0] s, input logic [9:0] m, input logic on);
      int sum;
      sum = int'(s) + int'(m) * 16 + (on ? 32'h2000 : 0);
      return (sum > 32'hFFFF) ? {1'b1, 16'hFFFF} : {1'b0, sum[15:0]};
   endfunction

   task automatic run_sample(input logic [15:0] ssp, input logic [9:0] ml, input logic [9:0] mr,
                             input logic bitv, input logic en, input logic mute, input logic clr,
                             output logic [15:0] l, output logic [15:0] r, output logic sat,
                             output logic got);
      int n;
      mix.ssp_audio_i   = ssp;
      mix.mb_audio_l_i  = ml;
      mix.mb_audio_r_i  = mr;
      mix.speaker_bit_i = bitv;
      mix.speaker_en_i  = en;
      mix.mute_i        = mute;
      if (clr) begin
         @(negedge clk_pixel);
         mix.sat_clear_i = 1'b1;
         @(negedge clk_pixel);
         mix.sat_clear_i = 1'b0;
      end
      n = 0;
      while (mix.sample_valid_o !== 1'b1 && n < 3 * DIV) begin
         @(negedge clk_pixel);
         n++;
      end
      got = (n < 3 * DIV);
      l   = mix.sample_l_o;
      r   = mix.sample_r_o;
      sat = mix.sat_flag_o;
      @(negedge clk_pixel);
   endtask

   task automatic step(input logic [15:0] ssp, input logic [9:0] ml, input logic [9:0] mr,
                       input logic bitv, input logic en, input logic mute, input logic clr,
                       input string tag, output logic [15:0] l, output logic [15:0] r,
                       output logic sat);
      logic on, got;
      logic [16:0] el, er;
      if (clr) sat_m = 1'b0;
      on = spk_prev_m && (spk_cnt_m != 0) && en;
      if (bitv != spk_prev_m) spk_cnt_m = PLEN;
      else if (spk_cnt_m != 0) spk_cnt_m--;
      spk_prev_m = bitv;
      el = mix_chan(ssp, ml, on);
      er = mix_chan(ssp, mr, on);
      sat_m = sat_m | el[16] | er[16];
      run_sample(ssp, ml, mr, bitv, en, mute, clr, l, r, sat, got);
      if (!got) timeout({tag, "_valid"});
      else begin
         check({tag, "_model_l"}, l, mute ? 16'h0 : el[15:0]);
         check({tag, "_model_r"}, r, mute ? 16'h0 : er[15:0]);
         check({tag, "_model_sat"}, sat, sat_m);
      end
   endtask

   typedef struct {
      logic [15:0] ssp;
      logic [9:0]  ml;
      logic [9:0]  mr;
      logic        mute;
      logic        clr;
      logic [15:0] el;
      logic [15:0] er;
      logic        es;
   } vec_t;

   vec_t vecs [9];

   initial begin
      logic [15:0] l, r;
      logic        sat;
      logic        cur_bit;
      int          n, vcount;

      vecs[0] = '{16'h1000, 10'h010, 10'h020, 1'b0, 1'b0, 16'h1100, 16'h1200, 1'b0};
      vecs[1] = '{16'hFF00, 10'h3FF, 10'h000, 1'b0, 1'b0, 16'hFFFF, 16'hFF00, 1'b1};
      vecs[2] = '{16'h0000, 10'h000, 10'h000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
      vecs[3] = '{16'h0000, 10'h000, 10'h000, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0};
      vecs[4] = '{16'h1234, 10'h3FF, 10'h001, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
      vecs[5] = '{16'h1234, 10'h3FF, 10'h001, 1'b0, 1'b0, 16'h5224, 16'h1244, 1'b0};
      vecs[6] = '{16'hFFFF, 10'h000, 10'h000, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0};
      vecs[7] = '{16'hC010, 10'h3FF, 10'h3FF, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1};
      vecs[8] = '{16'h0001, 10'h000, 10'h000, 1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0};

      mix.ssp_audio_i = '0;  mix.mb_audio_l_i = '0;  mix.mb_audio_r_i = '0;
      mix.speaker_bit_i = 1'b0;  mix.speaker_en_i = 1'b0;
      mix.mute_i = 1'b0;  mix.sat_clear_i = 1'b0;
      mix_def.ssp_audio_i = '0;  mix_def.mb_audio_l_i = '0;  mix_def.mb_audio_r_i = '0;
      mix_def.speaker_bit_i = 1'b0;  mix_def.speaker_en_i = 1'b0;
      mix_def.mute_i = 1'b0;  mix_def.sat_clear_i = 1'b0;

      reset = 1'b1;
      repeat (3) @(negedge clk_pixel);
      check("rst_sample_l", mix.sample_l_o, 16'h0);
      check("rst_sample_r", mix.sample_r_o, 16'h0);
      check("rst_valid", mix.sample_valid_o, 1'b0);
      check("rst_sat", mix.sat_flag_o, 1'b0);
      check("rst_tick", mix.audio_tick_o, 1'b0);
      check("rst_def_tick", mix_def.audio_tick_o, 1'b0);
      reset = 1'b0;

      // Speaker idle and disabled: expectations are plain arithmetic constants.
      for (int i = 0; i < 9; i++) begin
         step(vecs[i].ssp, vecs[i].ml, vecs[i].mr, 1'b0, 1'b0, vecs[i].mute, vecs[i].clr,
              $sformatf("vec%0d", i), l, r, sat);
         check($sformatf("vec%0d_l", i), l, vecs[i].el);
         check($sformatf("vec%0d_r", i), r, vecs[i].er);
         check($sformatf("vec%0d_sat", i), sat, vecs[i].es);
      end

      // One toggle: silent on the first tick, SPEAKER_LEVEL for the next 255, then silent.
      for (int k = 1; k <= 258; k++) begin
         step(16'h0, 10'h0, 10'h0, 1'b1, 1'b1, 1'b0, 1'b0, "spk", l, r, sat);
         check($sformatf("spk_pulse_l_%0d", k), l, (k >= 2 && k <= 256) ? 16'h2000 : 16'h0);
         check($sformatf("spk_pulse_r_%0d", k), r, (k >= 2 && k <= 256) ? 16'h2000 : 16'h0);
      end
      for (int k = 1; k <= 3; k++) begin
         step(16'h0, 10'h0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0, "spk_low", l, r, sat);
         check($sformatf("spk_low_%0d", k), l, 16'h0);
      end
      for (int k = 1; k <= 4; k++) begin
         step(16'h0, 10'h0, 10'h0, 1'b1, 1'b1, 1'b0, 1'b0, "spk_rearm", l, r, sat);
         check($sformatf("spk_rearm_%0d", k), l, (k >= 2) ? 16'h2000 : 16'h0);
      end
      for (int k = 1; k <= 2; k++) begin
         step(16'h0, 10'h0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0, "spk_dis", l, r, sat);
         check($sformatf("spk_disabled_%0d", k), r, 16'h0);
      end

      // Reset during the right-channel pass aborts that sample.
      step(16'h0400, 10'h001, 10'h002, 1'b1, 1'b0, 1'b0, 1'b0, "pre_abort", l, r, sat);
      mix.ssp_audio_i = 16'h0500;
      n = 0;
      while (!mix.audio_tick_o && n < 2 * DIV) begin
         @(negedge clk_pixel);
         n++;
      end
      if (n >= 2 * DIV) timeout("abort_tick");
      repeat (6) @(posedge clk_pixel);
      #1 reset = 1'b1;
      @(negedge clk_pixel);
      @(negedge clk_pixel);
      check("abort_rst_l", mix.sample_l_o, 16'h0);
      check("abort_rst_r", mix.sample_r_o, 16'h0);
      reset = 1'b0;
      vcount = 0;
      repeat (15) begin
         @(negedge clk_pixel);
         if (mix.sample_valid_o) vcount++;
      end
      check("abort_no_valid", vcount, 0);
      check("abort_hold_l", mix.sample_l_o, 16'h0);
      spk_prev_m = 1'b0;
      spk_cnt_m  = 0;
      sat_m      = 1'b0;
      step(16'h0500, 10'h003, 10'h004, 1'b1, 1'b0, 1'b0, 1'b0, "post_abort", l, r, sat);
      check("post_abort_l", l, 16'h0530);
      check("post_abort_r", r, 16'h0540);

      cur_bit = 1'b1;
      for (int i = 0; i < 120; i++) begin
         logic [15:0] s;
         if ($urandom_range(0, 7) == 0) cur_bit = ~cur_bit;
         s = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h3000));
         step(s, 10'($urandom), 10'($urandom), cur_bit, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              $sformatf("rnd%0d", i), l, r, sat);
      end

      check("def_tick_count_ok", (def_ticks >= 3), 1'b1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
